misaligned_mem_ctrl: RTL and testbench
======================================

# misaligned_mem_ctrl

Sequencer between the memory stage and the data-memory port. It splits misaligned word and halfword accesses into two word-aligned beats and produces the byte enables and shifted store data for each beat. It stalls the pipeline while an access is in flight. It drives the writeback stage's `is_misaligned` flag and its capture enable so the first-beat read data is buffered before the second beat returns. Aligned accesses pass through as one beat.

## Interface
Parameters:
- `TIMEOUT`, default 255: maximum cycles a beat may wait for `mem_ready` before abort. 0 disables the timeout.

Ports:
- `clk` input 1: single clock; all state changes on posedge.
- `rst_n` input 1: reset, synchronous, active-low.
- `req_valid` input 1: memory-stage instruction requests an access this cycle.
- `req_ready` output 1: controller can accept a request (state IDLE).
- `req_is_load` input 1: request is a load.
- `req_is_store` input 1: request is a store.
- `req_opcode` input 5: 3–5 word, 6–8 halfword, 9–11 byte; other values are not memory ops.
- `req_addr` input 32: byte address.
- `req_wdata` input 32: store data, right-justified.
- `flush` input 1: pipeline flush (exception or interrupt).
- `mem_req` output 1: beat request, held until accepted.
- `mem_we` output 1: beat is a write.
- `mem_addr` output 32: word-aligned beat address (`[1:0]` is always 0).
- `mem_be` output 4: byte enables for the beat.
- `mem_wdata` output 32: lane-aligned store data.
- `mem_ready` input 1: beat completes in any cycle where `mem_req && mem_ready`.
- `stall` output 1: hold upstream pipeline.
- `wb_capture` output 1: writeback clock-enable pulse; latches the memory result.
- `wb_misaligned` output 1: to writeback `is_misaligned`.
- `done` output 1: final beat completed this cycle.
- `bus_err` output 1: one-cycle pulse on timeout abort.

## Operation
- Size comes from `req_opcode`:
  - Word: misaligned if `addr[1:0]!=0`.
  - Halfword: misaligned only if `addr[1:0]==3`.
  - Byte: never misaligned.
  - Request with neither load nor store set: ignored, `req_ready` stays 1.
- Let `off = addr[1:0]` and `n` = 4, 2 or 1 bytes.
- Beat 0:
  - `mem_addr = {addr[31:2],2'b00}`.
  - `mem_be` covers bytes `off .. min(off+n-1,3)`.
  - `mem_wdata = wdata << 8*off`.
- Beat 1 (misaligned only):
  - `mem_addr` = beat-0 address + 4, modulo 2^32 (0xFFFFFFFC wraps to 0).
  - `mem_be` covers bytes `0 .. off+n-5`.
  - `mem_wdata = wdata >> 8*(4-off)`.
- Address, enables, data and `mem_we` are registered at accept and constant for the duration of each beat.
- FSM states: IDLE, BEAT0, BEAT1.
  - IDLE, `req_valid` with load or store set: latch request, go to BEAT0.
  - BEAT0, beat completes, aligned: go to IDLE, pulse `done`.
  - BEAT0, beat completes, misaligned: go to BEAT1.
  - BEAT1, beat completes: go to IDLE, pulse `done`.
- `mem_req = (state != IDLE)`.
- `stall = (state != IDLE) && !done`.
- `wb_capture` pulses:
  - on a misaligned beat-0 completion;
  - on every `done` cycle.
- `wb_misaligned` is 1 from beat-0 completion of a misaligned access through its `done` cycle, then 0.
- Flush:
  - In BEAT0 with no beat completed yet and `mem_ready` low: return to IDLE next cycle; no `done`.
  - Once any beat has completed, or if `mem_ready` is high in the flush cycle: flush is ignored, so a split store is never left half-written.
  - In IDLE, flush blocks acceptance that cycle.
- Timeout:
  - A per-beat wait counter resets on beat entry.
  - When it reaches `TIMEOUT` with `mem_ready` low: pulse `bus_err`, go to IDLE, drop `mem_req`; no `done`.

## Timing
- All outputs reset to 0, and state resets to IDLE.
- Reset mid-access abandons the beat: `mem_req` is 0 in the cycle after `rst_n` is sampled low.
- Aligned access with zero-wait memory: accept at cycle N, `mem_req` at N+1, `done` at N+1. Latency 1.
- Misaligned access with zero-wait memory: beats at N+1 and N+2, `done` at N+2.
- Each wait state adds 1 cycle per beat.
- `req_ready` is combinational from state. Back-to-back requests are accepted the cycle after `done`.
- `mem_be` and `mem_addr` may only change in the cycle after a beat completes.
- Simultaneous flush and `mem_ready` in BEAT0: the beat completes and the flush is ignored.

## Test plan
- Load word at 0x1000, `mem_ready` tied 1 -> one beat: addr 0x1000, be 4'b1111, `done` at N+1, `wb_misaligned` 0.
- Load word at 0x1001 -> beat 0: 0x1000, be 1110, `wb_capture`. Beat 1: 0x1004, be 0001, `wb_misaligned` 1, `done`. Stall high for exactly 1 cycle.
- Store word 0xAABBCCDD at 0x1002:
  - beat 0: wdata 0xCCDD0000, be 1100;
  - beat 1: 0x1004, wdata 0x0000AABB, be 0011.
- Store halfword 0x1234 at 0xFFFFFFFF:
  - beat 0: 0xFFFFFFFC, be 1000, wdata 0x34000000;
  - beat 1: 0x00000000, be 0001, wdata 0x00000012.
- `TIMEOUT`=4, `mem_ready` held 0 -> `bus_err` pulse after 4 wait cycles, then IDLE; no `done`.
- Flush in BEAT0 with `mem_ready` 0 -> IDLE, no beats issued.
- Flush after a misaligned store's beat 0 -> beat 1 still issued and `done` pulses.
- Reset asserted during BEAT1 -> all outputs 0 the next cycle.

Source files
------------

// File: rtl/misaligned_mem_ctrl.sv
// Splits misaligned word/halfword accesses into two word-aligned memory beats,
// drives byte enables, lane-shifted store data, pipeline stall and writeback capture.
module misaligned_mem_ctrl #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_is_load,
   input  logic        req_is_store,
   input  logic [4:0]  req_opcode,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic        flush,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic        mem_ready,
   output logic        stall,
   output logic        wb_capture,
   output logic        wb_misaligned,
   output logic        done,
   output logic        bus_err
);

   typedef enum logic [1:0] {
      IDLE,
      BEAT0,
      BEAT1
   } state_t;

   state_t      state;
   logic        mis_q;
   logic [31:0] addr1_q;
   logic [3:0]  be1_q;
   logic [31:0] wdata1_q;
   logic [31:0] wait_cnt;

   logic [3:0]  size_mask;
   logic [7:0]  be_span;
   logic [63:0] wdata_span;
   logic [31:0] beat0_addr;
   logic        accept;
   logic        beat0_split_done;
   logic        flush_abort;
   logic        timeout_hit;
   logic        leave;

   always_comb begin
      size_mask = 4'b0000;
      case (req_opcode)
         5'd3, 5'd4, 5'd5:  size_mask = 4'b1111;
         5'd6, 5'd7, 5'd8:  size_mask = 4'b0011;
         5'd9, 5'd10, 5'd11: size_mask = 4'b0001;
         default:           size_mask = 4'b0000;
      endcase
   end

   // The upper half of each span is what spills into the next word (beat 1).
   assign be_span    = {4'b0000, size_mask} << req_addr[1:0];
   assign wdata_span = {32'd0, req_wdata} << {req_addr[1:0], 3'b000};
   assign beat0_addr = {req_addr[31:2], 2'b00};

   assign accept = (state == IDLE) && req_valid && (req_is_load || req_is_store) &&
                   (size_mask != 4'b0000) && !flush;

   assign beat0_split_done = (state == BEAT0) && mem_ready && mis_q;
   assign done             = ((state == BEAT0) && mem_ready && !mis_q) ||
                             ((state == BEAT1) && mem_ready);
   assign flush_abort      = (state == BEAT0) && flush && !mem_ready;
   assign timeout_hit      = (TIMEOUT != 0) && (state != IDLE) && !mem_ready &&
                             (wait_cnt == TIMEOUT);
   assign bus_err          = timeout_hit && !flush_abort;
   assign leave            = done || flush_abort || bus_err;

   assign req_ready     = (state == IDLE);
   assign mem_req       = (state != IDLE);
   assign stall         = (state != IDLE) && !done;
   assign wb_capture    = beat0_split_done || done;
   assign wb_misaligned = beat0_split_done || (state == BEAT1);

   // Any way out of a beat (completion, flush, timeout) clears the port back to zero.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         mis_q     <= 1'b0;
         addr1_q   <= 32'd0;
         be1_q     <= 4'd0;
         wdata1_q  <= 32'd0;
         wait_cnt  <= 32'd0;
         mem_we    <= 1'b0;
         mem_addr  <= 32'd0;
         mem_be    <= 4'd0;
         mem_wdata <= 32'd0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  state     <= BEAT0;
                  mis_q     <= (be_span[7:4] != 4'b0000);
                  addr1_q   <= beat0_addr + 32'd4;
                  be1_q     <= be_span[7:4];
                  wdata1_q  <= wdata_span[63:32];
                  wait_cnt  <= 32'd0;
                  mem_we    <= req_is_store;
                  mem_addr  <= beat0_addr;
                  mem_be    <= be_span[3:0];
                  mem_wdata <= wdata_span[31:0];
               end
            end
            BEAT0: begin
               if (beat0_split_done) begin
                  state     <= BEAT1;
                  wait_cnt  <= 32'd0;
                  mem_addr  <= addr1_q;
                  mem_be    <= be1_q;
                  mem_wdata <= wdata1_q;
               end else if (!mem_ready && (TIMEOUT != 0)) begin
                  wait_cnt <= wait_cnt + 32'd1;
               end
            end
            BEAT1: begin
               if (!mem_ready && (TIMEOUT != 0)) begin
                  wait_cnt <= wait_cnt + 32'd1;
               end
            end
            default: state <= IDLE;
         endcase
         if (leave) begin
            state     <= IDLE;
            mis_q     <= 1'b0;
            wait_cnt  <= 32'd0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'd0;
            mem_be    <= 4'd0;
            mem_wdata <= 32'd0;
         end
      end
   end

endmodule

// File: tb/tb_misaligned_mem_ctrl.sv
// Directed testbench for misaligned_mem_ctrl with hand-computed beat values.
module tb_misaligned_mem_ctrl;

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_is_load;
   logic        req_is_store;
   logic [4:0]  req_opcode;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        flush;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic        mem_ready;
   logic        stall;
   logic        wb_capture;
   logic        wb_misaligned;
   logic        done;
   logic        bus_err;

   int vectors;
   int miscompares;

   misaligned_mem_ctrl #(.TIMEOUT(4)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_is_load   (req_is_load),
      .req_is_store  (req_is_store),
      .req_opcode    (req_opcode),
      .req_addr      (req_addr),
      .req_wdata     (req_wdata),
      .flush         (flush),
      .mem_req       (mem_req),
      .mem_we        (mem_we),
      .mem_addr      (mem_addr),
      .mem_be        (mem_be),
      .mem_wdata     (mem_wdata),
      .mem_ready     (mem_ready),
      .stall         (stall),
      .wb_capture    (wb_capture),
      .wb_misaligned (wb_misaligned),
      .done          (done),
      .bus_err       (bus_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectors++;
      if (observed !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
      end
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   // Present one request in an IDLE cycle, then drop it after the accepting edge.
   task automatic applyStimulus(input logic ld, input logic st, input logic [4:0] op,
                                input logic [31:0] addr, input logic [31:0] wdata);
      req_valid    = 1'b1;
      req_is_load  = ld;
      req_is_store = st;
      req_opcode   = op;
      req_addr     = addr;
      req_wdata    = wdata;
      settle();
      checkOutput("req_ready", req_ready, 1);
      nextCycle();
      req_valid    = 1'b0;
      req_is_load  = 1'b0;
      req_is_store = 1'b0;
      req_opcode   = 5'd0;
      req_addr     = 32'd0;
      req_wdata    = 32'd0;
   endtask

   task automatic checkBeat(input string tag, input logic [31:0] addr, input logic [3:0] be,
                            input logic [31:0] wdata, input logic we, input logic dn,
                            input logic wbm, input logic cap, input logic stl);
      checkOutput({tag, ".mem_req"}, mem_req, 1);
      checkOutput({tag, ".addr"}, mem_addr, addr);
      checkOutput({tag, ".be"}, {28'd0, mem_be}, {28'd0, be});
      checkOutput({tag, ".wdata"}, mem_wdata, wdata);
      checkOutput({tag, ".we"}, mem_we, we);
      checkOutput({tag, ".done"}, done, dn);
      checkOutput({tag, ".wb_mis"}, wb_misaligned, wbm);
      checkOutput({tag, ".wb_cap"}, wb_capture, cap);
      checkOutput({tag, ".stall"}, stall, stl);
   endtask

   initial begin
      vectors      = 0;
      miscompares  = 0;
      rst_n        = 1'b0;
      req_valid    = 1'b0;
      req_is_load  = 1'b0;
      req_is_store = 1'b0;
      req_opcode   = 5'd0;
      req_addr     = 32'd0;
      req_wdata    = 32'd0;
      flush        = 1'b0;
      mem_ready    = 1'b0;
      repeat (2) nextCycle();

      settle();
      checkOutput("rst.mem_req", mem_req, 0);
      checkOutput("rst.mem_addr", mem_addr, 0);
      checkOutput("rst.mem_be", {28'd0, mem_be}, 0);
      checkOutput("rst.mem_wdata", mem_wdata, 0);
      checkOutput("rst.stall", stall, 0);
      checkOutput("rst.done", done, 0);
      checkOutput("rst.bus_err", bus_err, 0);
      checkOutput("rst.wb_cap", wb_capture, 0);
      checkOutput("rst.wb_mis", wb_misaligned, 0);
      rst_n = 1'b1;
      nextCycle();
      settle();
      checkOutput("rst.req_ready", req_ready, 1);

      // Aligned load word, zero-wait memory
      mem_ready = 1'b1;
      applyStimulus(1'b1, 1'b0, 5'd3, 32'h0000_1000, 32'd0);
      settle();
      checkBeat("lw_al", 32'h0000_1000, 4'b1111, 32'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      nextCycle();
      settle();
      checkOutput("lw_al.idle_req", mem_req, 0);
      checkOutput("lw_al.idle_ready", req_ready, 1);

      // Misaligned load word at 0x1001
      applyStimulus(1'b1, 1'b0, 5'd3, 32'h0000_1001, 32'd0);
      settle();
      checkBeat("lw_mis.b0", 32'h0000_1000, 4'b1110, 32'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
      nextCycle();
      settle();
      checkBeat("lw_mis.b1", 32'h0000_1004, 4'b0001, 32'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      nextCycle();
      settle();
      checkOutput("lw_mis.idle_req", mem_req, 0);
      checkOutput("lw_mis.idle_wbm", wb_misaligned, 0);

      // Misaligned store word 0xAABBCCDD at 0x1002
      applyStimulus(1'b0, 1'b1, 5'd3, 32'h0000_1002, 32'hAABB_CCDD);
      settle();
      checkBeat("sw_mis.b0", 32'h0000_1000, 4'b1100, 32'hCCDD_0000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
      nextCycle();
      settle();
      checkBeat("sw_mis.b1", 32'h0000_1004, 4'b0011, 32'h0000_AABB, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      nextCycle();

      // Halfword store 0x1234 at 0xFFFFFFFF wraps into word 0
      applyStimulus(1'b0, 1'b1, 5'd6, 32'hFFFF_FFFF, 32'h0000_1234);
      settle();
      checkBeat("sh_wrap.b0", 32'hFFFF_FFFC, 4'b1000, 32'h3400_0000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
      nextCycle();
      settle();
      checkBeat("sh_wrap.b1", 32'h0000_0000, 4'b0001, 32'h0000_0012, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      nextCycle();

      // Byte store at offset 3 is never split
      applyStimulus(1'b0, 1'b1, 5'd9, 32'h0000_1003, 32'h0000_00AB);
      settle();
      checkBeat("sb_off3", 32'h0000_1000, 4'b1000, 32'hAB00_0000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      nextCycle();

      // Halfword store at offset 2 fits in one word
      applyStimulus(1'b0, 1'b1, 5'd7, 32'h0000_2002, 32'h0000_5678);
      settle();
      checkBeat("sh_off2", 32'h0000_2000, 4'b1100, 32'h5678_0000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      nextCycle();

      // Valid with neither load nor store is ignored
      applyStimulus(1'b0, 1'b0, 5'd3, 32'h0000_1000, 32'd0);
      settle();
      checkOutput("nop.mem_req", mem_req, 0);
      checkOutput("nop.req_ready", req_ready, 1);

      // Misaligned load word at offset 3 with one wait state on beat 0
      mem_ready = 1'b0;
      applyStimulus(1'b1, 1'b0, 5'd4, 32'h0000_2003, 32'd0);
      settle();
      checkBeat("lw_ws.wait", 32'h0000_2000, 4'b1000, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      nextCycle();
      mem_ready = 1'b1;
      settle();
      checkBeat("lw_ws.b0", 32'h0000_2000, 4'b1000, 32'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
      nextCycle();
      settle();
      checkBeat("lw_ws.b1", 32'h0000_2004, 4'b0111, 32'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      nextCycle();

      // Timeout: four wait cycles then a bus_err pulse
      mem_ready = 1'b0;
      applyStimulus(1'b1, 1'b0, 5'd3, 32'h0000_3000, 32'd0);
      for (int k = 1; k <= 5; k++) begin
         settle();
         checkOutput($sformatf("to.bus_err%0d", k), bus_err, (k == 5) ? 32'd1 : 32'd0);
         checkOutput($sformatf("to.done%0d", k), done, 0);
         checkOutput($sformatf("to.mem_req%0d", k), mem_req, 1);
         nextCycle();
      end
      settle();
      checkOutput("to.after_req", mem_req, 0);
      checkOutput("to.after_ready", req_ready, 1);
      checkOutput("to.after_err", bus_err, 0);

      // Flush in BEAT0 with memory not ready abandons the access
      applyStimulus(1'b1, 1'b0, 5'd3, 32'h0000_4000, 32'd0);
      flush = 1'b1;
      settle();
      checkOutput("fl0.mem_req", mem_req, 1);
      checkOutput("fl0.done", done, 0);
      checkOutput("fl0.bus_err", bus_err, 0);
      nextCycle();
      flush = 1'b0;
      settle();
      checkOutput("fl0.after_req", mem_req, 0);
      checkOutput("fl0.after_ready", req_ready, 1);
      checkOutput("fl0.after_done", done, 0);

      // Flush in IDLE blocks acceptance
      flush = 1'b1;
      applyStimulus(1'b1, 1'b0, 5'd3, 32'h0000_4000, 32'd0);
      flush = 1'b0;
      settle();
      checkOutput("fl_idle.mem_req", mem_req, 0);

      // Flush concurrent with beat-0 completion and during beat 1 is ignored
      mem_ready = 1'b1;
      applyStimulus(1'b0, 1'b1, 5'd3, 32'h0000_5001, 32'h1122_3344);
      flush = 1'b1;
      settle();
      checkBeat("fl_st.b0", 32'h0000_5000, 4'b1110, 32'h2233_4400, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
      nextCycle();
      settle();
      checkBeat("fl_st.b1", 32'h0000_5004, 4'b0001, 32'h0000_0011, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      flush = 1'b0;
      nextCycle();

      // Reset asserted during BEAT1
      applyStimulus(1'b1, 1'b0, 5'd3, 32'h0000_6001, 32'd0);
      settle();
      checkOutput("rst_b1.b0_addr", mem_addr, 32'h0000_6000);
      nextCycle();
      mem_ready = 1'b0;
      rst_n = 1'b0;
      settle();
      checkOutput("rst_b1.b1_addr", mem_addr, 32'h0000_6004);
      nextCycle();
      settle();
      checkOutput("rst_b1.mem_req", mem_req, 0);
      checkOutput("rst_b1.mem_addr", mem_addr, 0);
      checkOutput("rst_b1.mem_be", {28'd0, mem_be}, 0);
      checkOutput("rst_b1.mem_wdata", mem_wdata, 0);
      checkOutput("rst_b1.mem_we", mem_we, 0);
      checkOutput("rst_b1.stall", stall, 0);
      checkOutput("rst_b1.wb_mis", wb_misaligned, 0);
      checkOutput("rst_b1.wb_cap", wb_capture, 0);
      checkOutput("rst_b1.done", done, 0);
      checkOutput("rst_b1.bus_err", bus_err, 0);
      rst_n = 1'b1;
      nextCycle();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
